v_switch_scheduler: RTL and testbench

- Debounces N_SW switches with one shared sample-tick prescaler and one 4-sample history per switch; debounced level = OR of the history.
- Turns debounced press and long-press conditions into discrete events.
- Serialises events to a single consumer (control FSM or display logic) through a round-robin arbiter and a valid/ready handshake.
- Replaces one debouncer instance plus ad-hoc edge logic per switch.

---
 rtl/v_switch_scheduler.sv | 155 +++++++++++++++
 tb/tb_v_switch_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/v_switch_scheduler.sv
// Debounces N_SW switches, turns presses and long presses into events, and
// hands them one at a time to a single consumer through a round-robin arbiter.
module v_switch_scheduler #(
   parameter int N_SW       = 4,
   parameter int TICK_DIV   = 50000,
   parameter int LONG_TICKS = 1000,
   parameter int IDW        = $clog2(N_SW)
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic [N_SW-1:0] sw,
   output logic [N_SW-1:0] ssw,
   output logic            ev_valid,
   input  logic            ev_ready,
   output logic [IDW-1:0]  ev_id,
   output logic            ev_long,
   output logic            overflow,
   input  logic            ovf_clr,
   output logic            dbg_state,
   output logic [IDW-1:0]  dbg_rr_ptr
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HW = $clog2(LONG_TICKS + 1);

   typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     tick;
   logic [N_SW-1:0][3:0]     hist_q, hist_d;
   logic [N_SW-1:0]          ssw_q;
   logic [N_SW-1:0]          rise, long_c;
   logic [N_SW-1:0][HW-1:0]  hold_q, hold_d;
   logic [N_SW-1:0]          pend_p_q, pend_p_d, pend_l_q, pend_l_d;
   logic [N_SW-1:0]          clr_p, clr_l;
   logic                     overflow_q, overflow_d, drop;
   state_t                   state_q, state_d;
   logic                     ev_valid_q, ev_valid_d;
   logic [IDW-1:0]           ev_id_q, ev_id_d;
   logic                     ev_long_q, ev_long_d;
   logic [IDW-1:0]           rr_ptr_q, rr_ptr_d;
   logic                     win_found, win_long, capture;
   logic [IDW-1:0]           win_idx;

   assign tick  = (cnt_q == CW'(TICK_DIV - 1));
   assign cnt_d = tick ? '0 : cnt_q + CW'(1);

   // A press shows on the first high sample; release needs four low samples.
   always_comb begin
      hist_d = hist_q;
      hold_d = hold_q;
      ssw    = '0;
      long_c = '0;
      for (int i = 0; i < N_SW; i++) begin
         ssw[i] = |hist_q[i];
         if (tick) hist_d[i] = {hist_q[i][2:0], sw[i]};
         if (!ssw[i]) begin
            hold_d[i] = '0;
         end else if (tick && hold_q[i] != HW'(LONG_TICKS)) begin
            hold_d[i] = hold_q[i] + HW'(1);
            long_c[i] = (hold_q[i] == HW'(LONG_TICKS - 1));
         end
      end
   end

   assign rise = ssw & ~ssw_q;

   // Round-robin scan from rr_ptr; a press outranks a long press on one switch.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < N_SW; k++) begin
         int idx;
         idx = (int'(rr_ptr_q) + k) % N_SW;
         if (!win_found && (pend_p_q[idx] || pend_l_q[idx])) begin
            win_found = 1'b1;
            win_idx   = IDW'(idx);
         end
      end
      win_long = ~pend_p_q[win_idx];
   end

   // Handshake: an event transfers on a clock edge where ev_valid and ev_ready
   // are both high; while ev_valid is high and ev_ready low, ev_id/ev_long hold.
   assign capture = win_found && (state_q == IDLE || ev_ready);

   always_comb begin
      state_d    = state_q;
      ev_valid_d = ev_valid_q;
      ev_id_d    = ev_id_q;
      ev_long_d  = ev_long_q;
      rr_ptr_d   = rr_ptr_q;
      clr_p      = '0;
      clr_l      = '0;
      if (capture) begin
         ev_id_d    = win_idx;
         ev_long_d  = win_long;
         ev_valid_d = 1'b1;
         state_d    = OFFER;
         rr_ptr_d   = (win_idx == IDW'(N_SW - 1)) ? '0 : win_idx + IDW'(1);
         if (win_long) clr_l[win_idx] = 1'b1;
         else          clr_p[win_idx] = 1'b1;
      end else if (state_q == OFFER && ev_ready) begin
         ev_valid_d = 1'b0;
         state_d    = IDLE;
      end
   end

   always_comb begin
      pend_p_d   = (pend_p_q & ~clr_p) | rise;
      pend_l_d   = (pend_l_q & ~clr_l) | long_c;
      drop       = |(rise & pend_p_q & ~clr_p) || |(long_c & pend_l_q & ~clr_l);
      overflow_d = overflow_q;
      if (ovf_clr) overflow_d = 1'b0;
      if (drop)    overflow_d = 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q      <= '0;
         hist_q     <= '0;
         ssw_q      <= '0;
         hold_q     <= '0;
         pend_p_q   <= '0;
         pend_l_q   <= '0;
         overflow_q <= 1'b0;
         state_q    <= IDLE;
         ev_valid_q <= 1'b0;
         ev_id_q    <= '0;
         ev_long_q  <= 1'b0;
         rr_ptr_q   <= '0;
      end else begin
         cnt_q      <= cnt_d;
         hist_q     <= hist_d;
         ssw_q      <= ssw;
         hold_q     <= hold_d;
         pend_p_q   <= pend_p_d;
         pend_l_q   <= pend_l_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
         ev_valid_q <= ev_valid_d;
         ev_id_q    <= ev_id_d;
         ev_long_q  <= ev_long_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign ev_valid   = ev_valid_q;
   assign ev_id      = ev_id_q;
   assign ev_long    = ev_long_q;
   assign overflow   = overflow_q;
   assign dbg_state  = (state_q == OFFER);
   assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_v_switch_scheduler.sv
// Directed bench for v_switch_scheduler with TICK_DIV=4, LONG_TICKS=8; events
// are checked against an expected queue by a monitor on the falling edge.
module tb_v_switch_scheduler;

   localparam int N_SW = 4;
   localparam int IDW  = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N_SW-1:0] sw;
   logic [N_SW-1:0] ssw;
   logic            ev_valid;
   logic            ev_ready;
   logic [IDW-1:0]  ev_id;
   logic            ev_long;
   logic            overflow;
   logic            ovf_clr;
   logic            dbg_state;
   logic [IDW-1:0]  dbg_rr_ptr;

   logic [IDW:0] exp_q[$];
   int n_chk  = 0;
   int n_pass = 0;
   int cyc_cnt;

   v_switch_scheduler #(
      .N_SW(N_SW), .TICK_DIV(4), .LONG_TICKS(8), .IDW(IDW)
   ) dut (
      .clock(clk), .reset_n(rst_n), .sw(sw), .ssw(ssw),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_id(ev_id),
      .ev_long(ev_long), .overflow(overflow), .ovf_clr(ovf_clr),
      .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
   );

   // clock / reset-relative cycle count (tick edges are cycles 4, 8, ...)
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc_cnt <= 0;
      else        cyc_cnt <= cyc_cnt + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic after_tick(input int n = 1);
      repeat (n) begin
         do step(); while (cyc_cnt % 4 != 0);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && ev_valid && ev_ready) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            $display("FAIL event_unexpected: got id=%0d long=%0d expected none", ev_id, ev_long);
         end else begin
            logic [IDW:0] e;
            e = exp_q.pop_front();
            if ({ev_id, ev_long} == e) n_pass++;
            else $display("FAIL event: got id=%0d long=%0d expected id=%0d long=%0d",
                          ev_id, ev_long, e[IDW:1], e[0]);
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      sw       = '0;
      ev_ready = 1'b0;
      ovf_clr  = 1'b0;
      step(3);
      chk("reset_ssw", int'(ssw), 0);
      chk("reset_valid", int'(ev_valid), 0);
      chk("reset_ovf", int'(overflow), 0);
      chk("reset_id", int'(ev_id), 0);
      chk("reset_rr", int'(dbg_rr_ptr), 0);

      // press: first tick 4 clocks after release, event 2 clocks after ssw
      sw       = 4'b0001;
      ev_ready = 1'b1;
      rst_n    = 1'b1;
      exp_q.push_back({2'd0, 1'b0});
      step(3);
      chk("first_tick_not_yet", int'(ssw[0]), 0);
      step();
      chk("press_ssw", int'(ssw[0]), 1);
      chk("press_valid_e0", int'(ev_valid), 0);
      step();
      chk("press_valid_e1", int'(ev_valid), 0);
      step();
      chk("press_valid_e2", int'(ev_valid), 1);
      chk("press_id", int'(ev_id), 0);
      chk("press_long", int'(ev_long), 0);
      step();
      chk("press_one_cycle", int'(ev_valid), 0);

      // glitch: two low samples keep ssw high; sw0 stays held long enough for a long press
      exp_q.push_back({2'd0, 1'b1});
      after_tick();
      sw[0] = 1'b0;
      after_tick();
      chk("glitch_ssw_a", int'(ssw[0]), 1);
      after_tick();
      sw[0] = 1'b1;
      chk("glitch_ssw_b", int'(ssw[0]), 1);
      after_tick(8);
      sw[0] = 1'b0;
      after_tick(3);
      chk("release_3_low", int'(ssw[0]), 1);
      after_tick();
      chk("release_4_low", int'(ssw[0]), 0);
      chk("sw0_events_done", exp_q.size(), 0);

      // long press on switch 1
      exp_q.push_back({2'd1, 1'b0});
      exp_q.push_back({2'd1, 1'b1});
      sw[1] = 1'b1;
      after_tick(30);
      sw[1] = 1'b0;
      after_tick(6);
      chk("long_events_done", exp_q.size(), 0);
      chk("long_ssw_low", int'(ssw), 0);

      // grant switch 0 so the scan starts at 1
      exp_q.push_back({2'd0, 1'b0});
      sw[0] = 1'b1;
      after_tick();
      sw[0] = 1'b0;
      after_tick(6);
      chk("rr_after_sw0", int'(dbg_rr_ptr), 1);

      // round-robin under stall
      ev_ready = 1'b0;
      exp_q.push_back({2'd1, 1'b0});
      exp_q.push_back({2'd2, 1'b0});
      exp_q.push_back({2'd3, 1'b0});
      sw = 4'b1110;
      after_tick();
      sw = 4'b0000;
      step(2);
      for (int c = 0; c < 20; c++) begin
         chk("stall_hold", int'({ev_valid, ev_id, ev_long}), int'({1'b1, 2'd1, 1'b0}));
         step();
      end
      ev_ready = 1'b1;
      chk("rr_id1", int'({ev_valid, ev_id}), int'({1'b1, 2'd1}));
      step();
      chk("rr_id2", int'({ev_valid, ev_id}), int'({1'b1, 2'd2}));
      step();
      chk("rr_id3", int'({ev_valid, ev_id}), int'({1'b1, 2'd3}));
      step();
      chk("rr_done", int'(ev_valid), 0);
      after_tick(6);

      // overflow: sw3 occupies the offer, sw2 pends, re-press of sw2 is dropped
      ev_ready = 1'b0;
      exp_q.push_back({2'd3, 1'b0});
      exp_q.push_back({2'd2, 1'b0});
      after_tick();
      sw[3] = 1'b1;
      after_tick();
      sw[3] = 1'b0;
      sw[2] = 1'b1;
      after_tick();
      sw[2] = 1'b0;
      after_tick(4);
      chk("ovf_sw2_released", int'(ssw[2]), 0);
      chk("ovf_not_yet", int'(overflow), 0);
      sw[2] = 1'b1;
      after_tick();
      sw[2] = 1'b0;
      step(2);
      chk("ovf_set", int'(overflow), 1);
      chk("ovf_offer_id3", int'({ev_valid, ev_id}), int'({1'b1, 2'd3}));
      ev_ready = 1'b1;
      step(4);
      chk("ovf_sticky", int'(overflow), 1);
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      chk("ovf_cleared", int'(overflow), 0);
      after_tick(6);
      chk("ovf_events_done", exp_q.size(), 0);

      // reset in the middle of an offer
      ev_ready = 1'b0;
      after_tick();
      sw[0] = 1'b1;
      after_tick();
      step(2);
      chk("pre_reset_valid", int'(ev_valid), 1);
      chk("pre_reset_rr", int'(dbg_rr_ptr), 1);
      rst_n = 1'b0;
      #1;
      chk("midreset_valid", int'(ev_valid), 0);
      chk("midreset_ssw", int'(ssw), 0);
      chk("midreset_ovf", int'(overflow), 0);
      chk("midreset_rr", int'(dbg_rr_ptr), 0);
      chk("midreset_state", int'(dbg_state), 0);
      step(2);
      rst_n    = 1'b1;
      ev_ready = 1'b1;
      exp_q.push_back({2'd0, 1'b0});
      step(3);
      chk("rerelease_no_tick", int'(ssw[0]), 0);
      step();
      chk("rerelease_tick", int'(ssw[0]), 1);
      sw[0] = 1'b0;
      after_tick(8);

      chk("final_queue_empty", exp_q.size(), 0);
      chk("final_valid", int'(ev_valid), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
